alu_exec_unit: RTL and testbench



---
 rtl/alu_exec_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with single-cycle logic/shift/arith ops and iterative signed MUL/DIV.
// Optional macro ALU_FAST_MUL_EN selects a one-cycle combinational multiplier instead.
module alu_exec_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   In_Valid,
    input  logic [3:0]             ALU_Control,
    input  logic [DATA_WIDTH-1:0]  A,
    input  logic [DATA_WIDTH-1:0]  B,
    input  logic [SHAMT_WIDTH-1:0] Shamt,
    output logic                   Busy,
    output logic                   Out_Valid,
    output logic [DATA_WIDTH-1:0]  Result,
    output logic [DATA_WIDTH-1:0]  Hi,
    output logic                   Zero,
    output logic                   Div_By_Zero
);

    localparam int W = DATA_WIDTH;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_DIV = 4'b1011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [2*W-1:0]           r_acc;
    logic [W-1:0]             r_opnd;
    logic [SHAMT_WIDTH-1:0]   r_cnt;
    logic                     r_neg_res;
    logic                     r_neg_rem;
    logic [W-1:0]             r_result;
    logic [W-1:0]             r_hi;
    logic                     r_zero;
    logic                     r_out_valid;
    logic                     r_div_by_zero;

    logic signed [W-1:0]      w_a_s;
    logic signed [W-1:0]      w_b_s;
    logic [W-1:0]             w_a_mag;
    logic [W-1:0]             w_b_mag;
    logic [W-1:0]             w_alu;
    logic                     w_accept;
    logic                     w_is_mul;
    logic                     w_is_div;
    logic                     w_last;
    logic [2*W-1:0]           w_step;
    logic [W-1:0]             w_fin_lo;
    logic [W-1:0]             w_fin_hi;

    function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] x);
        logic signed [W-1:0] neg;
        neg = -x;
        return x[W-1] ? neg : x;
    endfunction

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    function automatic logic [2*W-1:0] mul_step(input logic [2*W-1:0] p, input logic [W-1:0] m);
        logic [W:0] sum;
        sum = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, m} : {(W+1){1'b0}});
        return {sum, p[W-1:1]};
    endfunction

    // Restoring division on {remainder, dividend/quotient}; quotient bits shift in at the LSB.
    function automatic logic [2*W-1:0] div_step(input logic [2*W-1:0] rq, input logic [W-1:0] d);
        logic [W:0]   sh;
        logic [W-1:0] diff;
        logic         ge;
        sh   = rq[2*W-1:W-1];
        ge   = (sh >= {1'b0, d});
        diff = sh[W-1:0] - d;
        return ge ? {diff, rq[W-2:0], 1'b1} : {sh[W-1:0], rq[W-2:0], 1'b0};
    endfunction

    function automatic logic [W-1:0] alu_op(input logic [3:0] op,
                                            input logic signed [W-1:0] a,
                                            input logic signed [W-1:0] b,
                                            input logic [SHAMT_WIDTH-1:0] sh);
        logic [W-1:0] res;
        res = '0;
        case (op)
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_ADD: res = a + b;
            OP_SUB: res = a - b;
            OP_XOR: res = a ^ b;
            OP_NOR: res = ~(a | b);
            OP_SLT: res = (a < b) ? W'(1) : '0;
            OP_SLL: res = b << sh;
            OP_SRL: res = $unsigned(b) >> sh;
            OP_SRA: res = b >>> sh;
            default: res = '0;
        endcase
        return res;
    endfunction

    assign w_a_s    = A;
    assign w_b_s    = B;
    assign w_a_mag  = magnitude(w_a_s);
    assign w_b_mag  = magnitude(w_b_s);
    assign w_alu    = alu_op(ALU_Control, w_a_s, w_b_s, Shamt);
    assign w_accept = In_Valid && (r_state == S_IDLE);
    assign w_is_div = (ALU_Control == OP_DIV) && (B != '0);
    assign w_last   = (r_cnt == SHAMT_WIDTH'(W - 1));

`ifdef ALU_FAST_MUL_EN
    logic signed [2*W-1:0] w_fast_prod;
    assign w_fast_prod = w_a_s * w_b_s;
    assign w_is_mul    = 1'b0;
`else
    assign w_is_mul    = (ALU_Control == OP_MUL);
`endif

    assign w_step = (r_state == S_DIV) ? div_step(r_acc, r_opnd) : mul_step(r_acc, r_opnd);

    // Sign correction applied to the final iteration's value.
    always_comb begin
        logic [2*W-1:0] prod;
        logic [W-1:0]   quo;
        logic [W-1:0]   rem;
        prod     = r_neg_res ? -w_step : w_step;
        quo      = r_neg_res ? -w_step[W-1:0] : w_step[W-1:0];
        rem      = r_neg_rem ? -w_step[2*W-1:W] : w_step[2*W-1:W];
        w_fin_lo = prod[W-1:0];
        w_fin_hi = prod[2*W-1:W];
        if (r_state == S_DIV) begin
            w_fin_lo = quo;
            w_fin_hi = rem;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul)
                    w_next_state = S_MUL;
                else if (w_accept && w_is_div)
                    w_next_state = S_DIV;
            end
            S_MUL, S_DIV: begin
                if (w_last)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // The first iteration is folded into the accept edge so the last lands DATA_WIDTH-1 edges later.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_result      <= '0;
            r_hi          <= '0;
            r_zero        <= 1'b0;
            r_out_valid   <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_out_valid   <= 1'b0;
            r_div_by_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_acc     <= mul_step({{W{1'b0}}, w_b_mag}, w_a_mag);
                            r_opnd    <= w_a_mag;
                            r_neg_res <= A[W-1] ^ B[W-1];
                            r_neg_rem <= A[W-1];
                            r_cnt     <= SHAMT_WIDTH'(1);
                        end else if (w_is_div) begin
                            r_acc     <= div_step({{W{1'b0}}, w_a_mag}, w_b_mag);
                            r_opnd    <= w_b_mag;
                            r_neg_res <= A[W-1] ^ B[W-1];
                            r_neg_rem <= A[W-1];
                            r_cnt     <= SHAMT_WIDTH'(1);
                        end else if (ALU_Control == OP_DIV) begin
                            r_result      <= '1;
                            r_hi          <= A;
                            r_zero        <= 1'b0;
                            r_out_valid   <= 1'b1;
                            r_div_by_zero <= 1'b1;
`ifdef ALU_FAST_MUL_EN
                        end else if (ALU_Control == OP_MUL) begin
                            r_result    <= w_fast_prod[W-1:0];
                            r_hi        <= w_fast_prod[2*W-1:W];
                            r_zero      <= (w_fast_prod[W-1:0] == '0);
                            r_out_valid <= 1'b1;
`endif
                        end else begin
                            r_result    <= w_alu;
                            r_hi        <= '0;
                            r_zero      <= (w_alu == '0);
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_last) begin
                        r_result    <= w_fin_lo;
                        r_hi        <= w_fin_hi;
                        r_zero      <= (w_fin_lo == '0);
                        r_out_valid <= 1'b1;
                    end else begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + SHAMT_WIDTH'(1);
                    end
                end
            endcase
        end
    end

    assign Busy        = (r_state != S_IDLE);
    assign Out_Valid   = r_out_valid;
    assign Result      = r_result;
    assign Hi          = r_hi;
    assign Zero        = r_zero;
    assign Div_By_Zero = r_div_by_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: single-cycle ops, MUL/DIV, reset abort, back-to-back.
module tb_alu_exec_unit;

    logic        Clk;
    logic        Reset;
    logic        In_Valid;
    logic [3:0]  ALU_Control;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  Shamt;
    logic        Busy;
    logic        Out_Valid;
    logic [31:0] Result;
    logic [31:0] Hi;
    logic        Zero;
    logic        Div_By_Zero;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef ALU_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_LAT  = 32;
    localparam int MUL_BUSY = 31;
`endif

    alu_exec_unit #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .In_Valid    (In_Valid),
        .ALU_Control (ALU_Control),
        .A           (A),
        .B           (B),
        .Shamt       (Shamt),
        .Busy        (Busy),
        .Out_Valid   (Out_Valid),
        .Result      (Result),
        .Hi          (Hi),
        .Zero        (Zero),
        .Div_By_Zero (Div_By_Zero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        @(negedge Clk);
        ALU_Control = op;
        A           = a;
        B           = b;
        Shamt       = sh;
        In_Valid    = 1'b1;
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
    endtask

    // Sample index 1 is the cycle right after the accept edge; lat=-1 when Out_Valid never arrives.
    task automatic wait_done(input int pulse_c, output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        for (int c = 1; c <= 64; c++) begin
            if (c > 1) begin
                @(posedge Clk);
                #1;
            end
            if (pulse_c > 0 && c == pulse_c) begin
                ALU_Control = 4'b0010;
                A           = 32'd1;
                B           = 32'd1;
                In_Valid    = 1'b1;
            end
            if (pulse_c > 0 && c == pulse_c + 2)
                In_Valid = 1'b0;
            if (Out_Valid) begin
                lat = c;
                break;
            end
            if (Busy)
                busy_n++;
        end
        In_Valid = 1'b0;
    endtask

    task automatic test_reset;
        Reset       = 1'b1;
        In_Valid    = 1'b0;
        ALU_Control = 4'b0000;
        A           = '0;
        B           = '0;
        Shamt       = '0;
        repeat (3) @(posedge Clk);
        #1;
        n_checks++;
        if ({Busy, Out_Valid, Zero, Div_By_Zero} !== 4'b0000)
            $display("FAIL reset_flags: got %b required 0000", {Busy, Out_Valid, Zero, Div_By_Zero});
        else n_pass++;
        n_checks++;
        if (Result !== 32'h0 || Hi !== 32'h0)
            $display("FAIL reset_data: got %h/%h required 0/0", Result, Hi);
        else n_pass++;
        Reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] r;
    } vec_t;

    task automatic test_single_cycle;
        vec_t v[15];
        v[0]  = '{4'b0010, 32'd5,         32'd7,         5'd0,  32'd12};
        v[1]  = '{4'b0110, 32'd9,         32'd9,         5'd0,  32'd0};
        v[2]  = '{4'b0111, 32'hFFFFFFFF,  32'd1,         5'd0,  32'd1};
        v[3]  = '{4'b1010, 32'd0,         32'h80000000,  5'd4,  32'hF8000000};
        v[4]  = '{4'b0000, 32'h0000F0F0,  32'h0000FF00,  5'd0,  32'h0000F000};
        v[5]  = '{4'b0001, 32'h0000F0F0,  32'h0000FF00,  5'd0,  32'h0000FFF0};
        v[6]  = '{4'b0100, 32'h0000F0F0,  32'h0000FF00,  5'd0,  32'h00000FF0};
        v[7]  = '{4'b1100, 32'h0000F0F0,  32'h0000FF00,  5'd0,  32'hFFFF000F};
        v[8]  = '{4'b1000, 32'd0,         32'd1,         5'd31, 32'h80000000};
        v[9]  = '{4'b1001, 32'd0,         32'h80000000,  5'd31, 32'h00000001};
        v[10] = '{4'b0010, 32'hFFFFFFFF,  32'd1,         5'd0,  32'h0};
        v[11] = '{4'b0110, 32'd0,         32'd1,         5'd0,  32'hFFFFFFFF};
        v[12] = '{4'b0011, 32'd3,         32'd4,         5'd0,  32'h0};
        v[13] = '{4'b0111, 32'd1,         32'hFFFFFFFF,  5'd0,  32'h0};
        v[14] = '{4'b1010, 32'd0,         32'h40000000,  5'd4,  32'h04000000};
        for (int i = 0; i < 15; i++) begin
            issue(v[i].op, v[i].a, v[i].b, v[i].sh);
            n_checks++;
            if (Out_Valid !== 1'b1 || Busy !== 1'b0 || Result !== v[i].r ||
                Zero !== (v[i].r == 32'h0) || Hi !== 32'h0)
                $display("FAIL single_%0d op=%b: got ov=%b busy=%b r=%h z=%b hi=%h required ov=1 busy=0 r=%h z=%b hi=0",
                         i, v[i].op, Out_Valid, Busy, Result, Zero, Hi, v[i].r, v[i].r == 32'h0);
            else n_pass++;
        end
        @(posedge Clk);
        #1;
        n_checks++;
        if (Out_Valid !== 1'b0 || Result !== 32'h04000000)
            $display("FAIL pulse_hold: got ov=%b r=%h required ov=0 r=04000000", Out_Valid, Result);
        else n_pass++;
    endtask

    task automatic test_mul;
        int lat, busy_n;
        issue(4'b0101, 32'hFFFFFFFD, 32'd7, 5'd0);
        wait_done(MUL_LAT > 1 ? 5 : 0, lat, busy_n);
        n_checks++;
        if (lat !== MUL_LAT || busy_n !== MUL_BUSY)
            $display("FAIL mul_timing: got lat=%0d busy=%0d required lat=%0d busy=%0d", lat, busy_n, MUL_LAT, MUL_BUSY);
        else n_pass++;
        n_checks++;
        if (Result !== 32'hFFFFFFEB || Hi !== 32'hFFFFFFFF || Zero !== 1'b0 || Busy !== 1'b0)
            $display("FAIL mul_neg: got r=%h hi=%h z=%b busy=%b required FFFFFFEB/FFFFFFFF/0/0", Result, Hi, Zero, Busy);
        else n_pass++;
        @(posedge Clk);
        #1;
        n_checks++;
        if (Out_Valid !== 1'b0 || Busy !== 1'b0 || Result !== 32'hFFFFFFEB)
            $display("FAIL mul_ignored_req: got ov=%b busy=%b r=%h required 0/0/FFFFFFEB", Out_Valid, Busy, Result);
        else n_pass++;
        issue(4'b0101, 32'h80000000, 32'd2, 5'd0);
        wait_done(0, lat, busy_n);
        n_checks++;
        if (lat !== MUL_LAT || Result !== 32'h0 || Hi !== 32'hFFFFFFFF || Zero !== 1'b1)
            $display("FAIL mul_minneg: got lat=%0d r=%h hi=%h z=%b required %0d/0/FFFFFFFF/1", lat, Result, Hi, Zero, MUL_LAT);
        else n_pass++;
        issue(4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
        wait_done(0, lat, busy_n);
        n_checks++;
        if (lat !== MUL_LAT || Result !== 32'h1 || Hi !== 32'h0)
            $display("FAIL mul_negneg: got lat=%0d r=%h hi=%h required %0d/1/0", lat, Result, Hi, MUL_LAT);
        else n_pass++;
    endtask

    task automatic test_div;
        int lat, busy_n;
        issue(4'b1011, 32'hFFFFFFF9, 32'd2, 5'd0);
        wait_done(0, lat, busy_n);
        n_checks++;
        if (lat !== 32 || busy_n !== 31 || Result !== 32'hFFFFFFFD || Hi !== 32'hFFFFFFFF || Div_By_Zero !== 1'b0)
            $display("FAIL div_neg: got lat=%0d busy=%0d r=%h hi=%h dbz=%b required 32/31/FFFFFFFD/FFFFFFFF/0",
                     lat, busy_n, Result, Hi, Div_By_Zero);
        else n_pass++;
        issue(4'b1011, 32'h12345678, 32'd0, 5'd0);
        n_checks++;
        if (Out_Valid !== 1'b1 || Busy !== 1'b0 || Result !== 32'hFFFFFFFF || Hi !== 32'h12345678 ||
            Div_By_Zero !== 1'b1 || Zero !== 1'b0)
            $display("FAIL div_by_zero: got ov=%b busy=%b r=%h hi=%h dbz=%b z=%b required 1/0/FFFFFFFF/12345678/1/0",
                     Out_Valid, Busy, Result, Hi, Div_By_Zero, Zero);
        else n_pass++;
        @(posedge Clk);
        #1;
        n_checks++;
        if (Div_By_Zero !== 1'b0 || Out_Valid !== 1'b0 || Hi !== 32'h12345678)
            $display("FAIL dbz_pulse: got dbz=%b ov=%b hi=%h required 0/0/12345678", Div_By_Zero, Out_Valid, Hi);
        else n_pass++;
        issue(4'b1011, 32'h80000000, 32'hFFFFFFFF, 5'd0);
        wait_done(0, lat, busy_n);
        n_checks++;
        if (lat !== 32 || Result !== 32'h80000000 || Hi !== 32'h0)
            $display("FAIL div_overflow: got lat=%0d r=%h hi=%h required 32/80000000/0", lat, Result, Hi);
        else n_pass++;
        issue(4'b1011, 32'd7, 32'hFFFFFFFE, 5'd0);
        wait_done(0, lat, busy_n);
        n_checks++;
        if (lat !== 32 || Result !== 32'hFFFFFFFD || Hi !== 32'h1)
            $display("FAIL div_pos_neg: got lat=%0d r=%h hi=%h required 32/FFFFFFFD/1", lat, Result, Hi);
        else n_pass++;
    endtask

    task automatic test_reset_abort;
        int ov_seen;
        issue(4'b1011, 32'd100, 32'd7, 5'd0);
        repeat (9) begin
            @(posedge Clk);
            #1;
        end
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        n_checks++;
        if (Busy !== 1'b0 || Out_Valid !== 1'b0 || Result !== 32'h0 || Hi !== 32'h0 ||
            Zero !== 1'b0 || Div_By_Zero !== 1'b0)
            $display("FAIL abort_state: got busy=%b ov=%b r=%h hi=%h z=%b dbz=%b required all 0",
                     Busy, Out_Valid, Result, Hi, Zero, Div_By_Zero);
        else n_pass++;
        Reset   = 1'b0;
        ov_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge Clk);
            #1;
            if (Out_Valid) ov_seen++;
        end
        n_checks++;
        if (ov_seen !== 0)
            $display("FAIL abort_no_valid: got %0d Out_Valid pulses required 0", ov_seen);
        else n_pass++;
        issue(4'b0010, 32'd2, 32'd3, 5'd0);
        n_checks++;
        if (Out_Valid !== 1'b1 || Result !== 32'd5 || Zero !== 1'b0)
            $display("FAIL abort_then_add: got ov=%b r=%h z=%b required 1/5/0", Out_Valid, Result, Zero);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int lat, busy_n;
        issue(4'b1011, 32'd100, 32'd7, 5'd0);
        wait_done(0, lat, busy_n);
        n_checks++;
        if (lat !== 32 || Result !== 32'd14 || Hi !== 32'd2 || Busy !== 1'b0)
            $display("FAIL b2b_div: got lat=%0d r=%h hi=%h busy=%b required 32/E/2/0", lat, Result, Hi, Busy);
        else n_pass++;
        ALU_Control = 4'b0010;
        A           = 32'd20;
        B           = 32'd22;
        In_Valid    = 1'b1;
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
        n_checks++;
        if (Out_Valid !== 1'b1 || Result !== 32'd42 || Hi !== 32'h0 || Busy !== 1'b0)
            $display("FAIL b2b_add: got ov=%b r=%h hi=%h busy=%b required 1/2A/0/0", Out_Valid, Result, Hi, Busy);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_single_cycle;
        test_mul;
        test_div;
        test_reset_abort;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
